// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-stage definitions: default PC geometry and the next-PC source
// encoding that the hazard unit also decodes.
package pc_sequencer_pkg;

    localparam int unsigned PC_W_DEF     = 12;
    localparam int unsigned RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        SRC_SEQ = 2'd0,
        SRC_BR  = 2'd1,
        SRC_JMP = 2'd2,
        SRC_JR  = 2'd3
    } pc_src_e;

    // Any source other than the sequential successor redirects fetch.
    function automatic logic is_redirect(input pc_src_e src);
        return src != SRC_SEQ;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode-to-fetch bus: decoded control flags and operands in, PC state out.
interface pc_sequencer_if #(
    parameter int unsigned PC_W  = 12,
    parameter int unsigned N_W   = 17,
    parameter int unsigned T_W   = 27,
    parameter int unsigned CNT_W = 16
);

    logic             stall;
    logic             instr_valid;
    logic             is_bne;
    logic             is_blt;
    logic             is_j;
    logic             is_jal;
    logic             is_jr;
    logic             is_bex;
    logic             is_not_eq;
    logic             is_less_than;
    logic [N_W-1:0]   imm_n;
    logic [T_W-1:0]   target_t;
    logic [31:0]      reg_b;

    logic [PC_W-1:0]  pc_out;
    logic [PC_W-1:0]  pc_next;
    logic             flush;
    logic             ras_hit;
    logic             ras_empty;
    logic             ras_full;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, instr_valid,
        output is_bne, is_blt, is_j, is_jal, is_jr, is_bex,
        output is_not_eq, is_less_than,
        output imm_n, target_t, reg_b,
        input  pc_out, pc_next, flush, ras_hit, ras_empty, ras_full, taken_cnt
    );

    modport slave (
        input  stall, instr_valid,
        input  is_bne, is_blt, is_j, is_jal, is_jr, is_bex,
        input  is_not_eq, is_less_than,
        input  imm_n, target_t, reg_b,
        output pc_out, pc_next, flush, ras_hit, ras_empty, ras_full, taken_cnt
    );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty leaves pointer and count untouched.
module pc_ras #(
    parameter int unsigned PC_W      = 12,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [PC_W-1:0]  mem [RAS_DEPTH];

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(RAS_DEPTH));
    assign top   = mem[ptr_q - PTR_W'(1)];

    // ptr_q is the next write slot; when full it already points at the oldest entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (pop) begin
            if (!empty) begin
                ptr_q   <= ptr_q - PTR_W'(1);
                count_q <= count_q - CNT_W'(1);
            end
        end else if (push) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (!full) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !pop) begin
            mem[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch-stage PC unit: next-PC select, redirect pulse, jr target
// checking against a return-address stack, and a saturating redirect counter.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned N_W       = 17,
    parameter int unsigned T_W       = 27,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = RESET_PC_DEF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic           clock,
    input  logic           reset_n,
    pc_sequencer_if.slave  bus
);

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  seq_pc;
    logic [PC_W-1:0]  br_target;
    logic [PC_W-1:0]  next_pc;
    logic [PC_W-1:0]  ras_top;
    logic [CNT_W-1:0] cnt_q;
    logic             flush_q;
    logic             hit_q;
    logic             br_taken;
    logic             bex_taken;
    logic             redirect;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_match;
    pc_src_e          src;

    assign seq_pc    = pc_q + PC_W'(1);
    assign br_target = seq_pc + bus.imm_n[PC_W-1:0];

    assign br_taken  = bus.instr_valid &
                       ((bus.is_bne & bus.is_not_eq) | (bus.is_blt & bus.is_less_than));
    assign bex_taken = bus.instr_valid & bus.is_bex & (|bus.reg_b);

    always_comb begin
        src = SRC_SEQ;
        if (bus.instr_valid) begin
            if (bus.is_jr) begin
                src = SRC_JR;
            end else if (bus.is_j | bus.is_jal | bex_taken) begin
                src = SRC_JMP;
            end else if (br_taken) begin
                src = SRC_BR;
            end
        end
    end

    always_comb begin
        next_pc = seq_pc;
        case (src)
            SRC_JR:  next_pc = bus.reg_b[PC_W-1:0];
            SRC_JMP: next_pc = bus.target_t[PC_W-1:0];
            SRC_BR:  next_pc = br_target;
            default: next_pc = seq_pc;
        endcase
    end

    assign redirect = is_redirect(src);

    // jal+jr together only pops: jr owns both the PC and the stack.
    assign ras_pop   = ~bus.stall & bus.instr_valid & bus.is_jr;
    assign ras_push  = ~bus.stall & bus.instr_valid & bus.is_jal & ~bus.is_jr;
    assign ras_match = ~ras_empty & (ras_top == bus.reg_b[PC_W-1:0]);

    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= PC_W'(RESET_PC);
            flush_q <= 1'b0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (bus.stall) begin
            flush_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            pc_q    <= next_pc;
            flush_q <= redirect;
            hit_q   <= ras_pop & ras_match;
            if (redirect && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.pc_next   = next_pc;
    assign bus.flush     = flush_q;
    assign bus.ras_hit   = hit_q;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.taken_cnt = cnt_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for the processor fetch stage; parametrised successor to the combinational next-PC adder.
- Holds the PC, selects the next PC from sequential/branch/jump/jr/bex sources, and supports stall.
- Adds a return-address stack (RAS) that checks jr targets, a registered redirect (flush) pulse, and a saturating taken-transfer counter.

Parameters:
- PC_W, 12, PC and address width (bits); all PC arithmetic is modulo 2^PC_W.
- N_W, 17, width of the I-type immediate field N.
- T_W, 27, width of the J-type target field T.
- RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.
- RESET_PC, 0, PC value loaded at reset.
- CNT_W, 16, width of the taken-transfer counter.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  1 = hold PC and all state
- instr_valid  in  1  decode flags below describe the instruction at pc_out
- is_bne, is_blt, is_j, is_jal, is_jr, is_bex  in  1 each  decoded opcode class
- is_not_eq  in  1  ALU compare result: operands not equal
- is_less_than  in  1  ALU compare result: operand A less than operand B
- imm_n  in  N_W  branch offset N (two's complement)
- target_t  in  T_W  jump target T
- reg_b  in  32  register operand: $rd for jr, $rstatus for bex
- pc_out  out  PC_W  current PC (registered)
- pc_next  out  PC_W  combinational next PC
- flush  out  1  registered pulse: previous update was a redirect
- ras_hit  out  1  registered pulse: the last jr matched the RAS prediction
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- taken_cnt  out  CNT_W  saturating count of redirects

Behaviour:
- Reset (asynchronous, active-low): pc_out=RESET_PC, flush=0, ras_hit=0, taken_cnt=0, RAS count=0 (ras_empty=1, ras_full=0). The RAS storage contents are don't-care.
- seq = pc_out+1 mod 2^PC_W; wrap-around is legal (all ones -> 0).
- Branch taken when instr_valid & ((is_bne & is_not_eq) | (is_blt & is_less_than)). Taken target = seq + imm_n[PC_W-1:0] mod 2^PC_W.
- bex taken when is_bex & reg_b != 0.
- Next-PC priority when instr_valid:
  - jr -> reg_b[PC_W-1:0]
  - else j/jal/taken bex -> target_t[PC_W-1:0]
  - else taken branch -> taken target
  - else seq
  - When instr_valid=0, pc_next=seq. Any other combination of flags is resolved purely by this priority.
- Update: on each clock edge with stall=0, pc_out<=pc_next.
  - flush<=1 if pc_next came from jr, jump, taken bex or taken branch; else 0.
  - taken_cnt increments on each redirect and saturates at all ones.
  - With stall=1, pc_out, the RAS and taken_cnt hold, and flush and ras_hit are driven to 0.
- RAS (only updated when stall=0 and instr_valid=1):
  - jal: push seq. When full, overwrite the oldest entry (circular buffer) and keep count=RAS_DEPTH.
  - jr: pop. ras_hit<=1 iff the stack was non-empty and top==reg_b[PC_W-1:0]; otherwise ras_hit<=0. Popping an empty stack keeps count=0 and does not change the pointer.
  - jal and jr both asserted: jr takes priority for the PC, and the RAS performs only the pop.
- Latency: decode flags to pc_out is 1 cycle. flush and ras_hit are asserted in the same cycle the new pc_out appears.
- reset_n asserted mid-operation clears all state immediately, regardless of stall.

Decomposition:
- Shared package: PC_W default, RESET_PC, and an enum for next-PC source {SRC_SEQ, SRC_BR, SRC_JMP, SRC_JR}, reused by the hazard unit.
- Sub-module: pc_ras (circular return-address stack), with ports push, pop, push_data, top, empty, full, and the same clock/reset.
- Everything else (source select, PC register, counter) stays in pc_sequencer.

Test Plan:
- Reset, then 3 cycles with instr_valid=0 and stall=0 -> pc_out goes 0,1,2,3; flush stays 0; taken_cnt=0.
- At pc=5: is_bne=1, is_not_eq=1, imm_n=-3 (17'h1FFFD) -> pc_out=3 next cycle, flush=1, taken_cnt=1. Same case with is_not_eq=0 -> pc_out=6, flush=0.
- At pc=10: jal with target_t=100 -> pc_out=100, RAS top=11. Then jr with reg_b=11 -> pc_out=11, ras_hit=1. Then jr with reg_b=20 on an empty RAS -> pc_out=20, ras_hit=0, ras_empty stays 1.
- 5 jals from pcs 1..5 with RAS_DEPTH=4 -> ras_full=1. Four jrs then return tops 6,5,4,3 with ras_hit=1 each; a fifth jr gives ras_hit=0.
- pc=12'hFFF with no control flow -> pc_out=0. bex with reg_b=0 -> sequential; bex with reg_b=7 and target_t=50 -> pc_out=50, flush=1.
- stall=1 for 3 cycles during a taken branch -> pc_out, RAS and taken_cnt unchanged, flush=0. Releasing the stall -> redirect occurs. reset_n pulsed low mid-stall -> pc_out=RESET_PC asynchronously.
